loproc_regbank_mp: RTL



---
 rtl/loproc_regbank_mp_pkg.sv | 17 +
 rtl/loproc_regbank_mp_if.sv | 30 +++
 rtl/loproc_regbank_mp_scoreboard.sv | 71 +++++++
 rtl/loproc_regbank_mp.sv | 86 ++++++++
 4 files changed

// File: rtl/loproc_regbank_mp_pkg.sv
// Shared defaults and address-qualification helper for the multi-port LoPROC register bank.
package loproc_regbank_mp_pkg;

  localparam int REG_BANK_DATA_WIDTH = 32;
  localparam int REG_BANK_DEPTH      = 32;
  localparam int REG_BANK_ADDR_WIDTH = 5;
  localparam int NUM_RD_PORTS        = 2;
  localparam int NUM_WR_PORTS        = 2;
  localparam int REG_BANK_ZERO_REG   = 1;

  // True when addr names a real, writable/reservable register.
  function automatic logic reg_addr_ok(input logic [31:0] addr, input logic [31:0] depth,
                                       input logic zero_reg);
    return (addr < depth) && !(zero_reg && (addr == 32'd0));
  endfunction

endpackage

// File: rtl/loproc_regbank_mp_if.sv
// Decode/writeback-facing bus of the register bank: read, write and reservation ports.
interface loproc_regbank_mp_if
  import loproc_regbank_mp_pkg::*;
#(
  parameter int DATA_WIDTH = REG_BANK_DATA_WIDTH,
  parameter int ADDR_WIDTH = REG_BANK_ADDR_WIDTH,
  parameter int NUM_RD     = NUM_RD_PORTS,
  parameter int NUM_WR     = NUM_WR_PORTS
);
  logic [NUM_RD-1:0]            rd_en;
  logic [NUM_RD*ADDR_WIDTH-1:0] rd_addr;
  logic [NUM_RD*DATA_WIDTH-1:0] rd_data;
  logic [NUM_RD-1:0]            rd_busy;
  logic [NUM_WR-1:0]            wr_en;
  logic [NUM_WR*ADDR_WIDTH-1:0] wr_addr;
  logic [NUM_WR*DATA_WIDTH-1:0] wr_data;
  logic                         rsv_en;
  logic [ADDR_WIDTH-1:0]        rsv_addr;
  logic                         rsv_ack;

  modport master (
    output rd_en, rd_addr, wr_en, wr_addr, wr_data, rsv_en, rsv_addr,
    input  rd_data, rd_busy, rsv_ack
  );

  modport slave (
    input  rd_en, rd_addr, wr_en, wr_addr, wr_data, rsv_en, rsv_addr,
    output rd_data, rd_busy, rsv_ack
  );
endinterface

// File: rtl/loproc_regbank_mp_scoreboard.sv
// Pending-bit scoreboard: write-clears, reservation-sets (set wins), rd_busy and rsv_ack registers.
module loproc_regbank_mp_scoreboard
  import loproc_regbank_mp_pkg::*;
#(
  parameter int DEPTH      = REG_BANK_DEPTH,
  parameter int ADDR_WIDTH = REG_BANK_ADDR_WIDTH,
  parameter int NUM_RD     = NUM_RD_PORTS,
  parameter int NUM_WR     = NUM_WR_PORTS,
  parameter int ZERO_REG   = REG_BANK_ZERO_REG
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [NUM_RD-1:0]            rd_en,
  input  logic [NUM_RD*ADDR_WIDTH-1:0] rd_addr,
  input  logic [NUM_WR-1:0]            wr_en,
  input  logic [NUM_WR*ADDR_WIDTH-1:0] wr_addr,
  input  logic                         rsv_en,
  input  logic [ADDR_WIDTH-1:0]        rsv_addr,
  output logic [NUM_RD-1:0]            rd_busy,
  output logic                         rsv_ack
);
  localparam logic ZERO_EN = (ZERO_REG != 0);

  logic [DEPTH-1:0]  pending_r;
  logic [DEPTH-1:0]  clr_mask_s;
  logic [DEPTH-1:0]  set_mask_s;
  logic [DEPTH-1:0]  pend_clr_s;
  logic              rsv_ok_s;
  logic [NUM_RD-1:0] busy_next_s;
  logic [NUM_RD-1:0] rd_busy_r;
  logic              rsv_ack_r;

  // Next pending state: readers see the post-clear, pre-reserve view
  always_comb begin
    clr_mask_s  = {DEPTH{1'b0}};
    set_mask_s  = {DEPTH{1'b0}};
    busy_next_s = {NUM_RD{1'b0}};
    rsv_ok_s    = rsv_en && reg_addr_ok(32'(rsv_addr), 32'(DEPTH), ZERO_EN);
    for (int k = 0; k < DEPTH; k++) begin
      for (int j = 0; j < NUM_WR; j++) begin
        clr_mask_s[k] = clr_mask_s[k] |
          (wr_en[j] && reg_addr_ok(32'(wr_addr[j*ADDR_WIDTH +: ADDR_WIDTH]), 32'(DEPTH), ZERO_EN) &&
           (wr_addr[j*ADDR_WIDTH +: ADDR_WIDTH] == ADDR_WIDTH'(k)));
      end
      set_mask_s[k] = rsv_ok_s && (rsv_addr == ADDR_WIDTH'(k));
    end
    pend_clr_s = pending_r & ~clr_mask_s;
    for (int i = 0; i < NUM_RD; i++) begin
      busy_next_s[i] = rd_en[i] &&
        reg_addr_ok(32'(rd_addr[i*ADDR_WIDTH +: ADDR_WIDTH]), 32'(DEPTH), ZERO_EN) &&
        pend_clr_s[rd_addr[i*ADDR_WIDTH +: ADDR_WIDTH]];
    end
  end

  // Scoreboard and flag registers
  always_ff @(posedge clk) begin
    if (rst) begin
      pending_r <= {DEPTH{1'b0}};
      rd_busy_r <= {NUM_RD{1'b0}};
      rsv_ack_r <= 1'b0;
    end else begin
      pending_r <= pend_clr_s | set_mask_s;
      rd_busy_r <= busy_next_s;
      rsv_ack_r <= rsv_ok_s;
    end
  end

  assign rd_busy = rd_busy_r;
  assign rsv_ack = rsv_ack_r;

endmodule

// File: rtl/loproc_regbank_mp.sv
// Multi-port LoPROC register bank: storage, write-port priority, write-to-read bypass.
module loproc_regbank_mp
  import loproc_regbank_mp_pkg::*;
#(
  parameter int DATA_WIDTH = REG_BANK_DATA_WIDTH,
  parameter int DEPTH      = REG_BANK_DEPTH,
  parameter int ADDR_WIDTH = REG_BANK_ADDR_WIDTH,
  parameter int NUM_RD     = NUM_RD_PORTS,
  parameter int NUM_WR     = NUM_WR_PORTS,
  parameter int ZERO_REG   = REG_BANK_ZERO_REG
) (
  input logic                clk,
  input logic                rst,
  loproc_regbank_mp_if.slave bus
);
  localparam logic ZERO_EN = (ZERO_REG != 0);

  logic [DATA_WIDTH-1:0]        mem_r [DEPTH];
  logic [NUM_WR-1:0]            wr_ok_s;
  logic [NUM_RD*DATA_WIDTH-1:0] rd_next_s;
  logic [NUM_RD*DATA_WIDTH-1:0] rd_data_r;

  // Qualify writes and build read data; later writers override earlier ones in the bypass
  always_comb begin
    wr_ok_s   = {NUM_WR{1'b0}};
    rd_next_s = {(NUM_RD*DATA_WIDTH){1'b0}};
    for (int j = 0; j < NUM_WR; j++) begin
      wr_ok_s[j] = bus.wr_en[j] &&
        reg_addr_ok(32'(bus.wr_addr[j*ADDR_WIDTH +: ADDR_WIDTH]), 32'(DEPTH), ZERO_EN);
    end
    for (int i = 0; i < NUM_RD; i++) begin
      if (bus.rd_en[i] &&
          reg_addr_ok(32'(bus.rd_addr[i*ADDR_WIDTH +: ADDR_WIDTH]), 32'(DEPTH), ZERO_EN)) begin
        rd_next_s[i*DATA_WIDTH +: DATA_WIDTH] = mem_r[bus.rd_addr[i*ADDR_WIDTH +: ADDR_WIDTH]];
        for (int j = 0; j < NUM_WR; j++) begin
          rd_next_s[i*DATA_WIDTH +: DATA_WIDTH] =
            (wr_ok_s[j] && (bus.wr_addr[j*ADDR_WIDTH +: ADDR_WIDTH] ==
                            bus.rd_addr[i*ADDR_WIDTH +: ADDR_WIDTH]))
              ? bus.wr_data[j*DATA_WIDTH +: DATA_WIDTH]
              : rd_next_s[i*DATA_WIDTH +: DATA_WIDTH];
        end
      end else begin
        rd_next_s[i*DATA_WIDTH +: DATA_WIDTH] = {DATA_WIDTH{1'b0}};
      end
    end
  end

  // Storage and read-data registers; the last non-blocking write per address wins
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < DEPTH; k++) begin
        mem_r[k] <= {DATA_WIDTH{1'b0}};
      end
      rd_data_r <= {(NUM_RD*DATA_WIDTH){1'b0}};
    end else begin
      for (int j = 0; j < NUM_WR; j++) begin
        if (wr_ok_s[j]) begin
          mem_r[bus.wr_addr[j*ADDR_WIDTH +: ADDR_WIDTH]] <= bus.wr_data[j*DATA_WIDTH +: DATA_WIDTH];
        end
      end
      rd_data_r <= rd_next_s;
    end
  end

  assign bus.rd_data = rd_data_r;

  loproc_regbank_mp_scoreboard #(
    .DEPTH      (DEPTH),
    .ADDR_WIDTH (ADDR_WIDTH),
    .NUM_RD     (NUM_RD),
    .NUM_WR     (NUM_WR),
    .ZERO_REG   (ZERO_REG)
  ) u_scoreboard (
    .clk      (clk),
    .rst      (rst),
    .rd_en    (bus.rd_en),
    .rd_addr  (bus.rd_addr),
    .wr_en    (bus.wr_en),
    .wr_addr  (bus.wr_addr),
    .rsv_en   (bus.rsv_en),
    .rsv_addr (bus.rsv_addr),
    .rd_busy  (bus.rd_busy),
    .rsv_ack  (bus.rsv_ack)
  );

endmodule
